mmio_multi_timer_core: RTL and testbench

- Parametrised multi-channel timer slot core for the MMIO slot bus; successor to the single system-timer slot (slot 0).
- Provides NUM_CH independent up-counters sharing one prescaled tick, each with free-run, periodic auto-reload and one-shot modes.
- Each channel has a sticky expiry flag; the combined interrupt is routed to the processor.
- Plugs into any slot of the MMIO controller using the standard cs/read/write/addr/wr_data/rd_data slot interface.

---
 rtl/mmio_multi_timer_core.sv | 146 ++++++++++++++
 tb/tb_mmio_multi_timer_core.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_multi_timer_core.sv
// Multi-channel MMIO timer slot: NUM_CH up-counters sharing one prescaled
// tick, each with free-run, periodic and one-shot modes, a sticky expiry
// flag and a per-channel interrupt enable. Four registers per channel.
module mmio_multi_timer_core #(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 32,
  parameter int TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        irq
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] MODE_PERIODIC = 2'b01;
  localparam logic [1:0] MODE_ONESHOT  = 2'b10;

  logic [PW-1:0]        presc_q, presc_d;
  logic                 tick;

  logic [CNT_WIDTH-1:0] cnt_q [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_CH];
  logic [CNT_WIDTH-1:0] per_q [NUM_CH];
  logic [CNT_WIDTH-1:0] per_d [NUM_CH];
  logic [1:0]           mode_q [NUM_CH];
  logic [1:0]           mode_d [NUM_CH];
  logic [NUM_CH-1:0]    en_q, en_d;
  logic [NUM_CH-1:0]    ien_q, ien_d;
  logic [NUM_CH-1:0]    exp_q, exp_d;

  logic [NUM_CH-1:0]    hit_cnt, hit_per, hit_ctl, hit_sts, set_exp;
  logic                 in_range;
  logic                 wr_ok;

  // Reads are side-effect free and upper write bits may be discarded.
  logic unused_inputs;
  assign unused_inputs = ^{read, wr_data};

  assign in_range = ({27'd0, addr} < 32'(NUM_CH * 4));
  assign wr_ok    = cs & write & in_range;

  // Shared prescaler: tick on the last count of each TICK_DIV window.
  assign tick    = (presc_q == PW'(TICK_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + 1'b1;

  // Per-channel next state: counting rules first, then register writes override.
  always_comb begin
    hit_cnt = '0;
    hit_per = '0;
    hit_ctl = '0;
    hit_sts = '0;
    set_exp = '0;
    en_d    = en_q;
    ien_d   = ien_q;
    exp_d   = exp_q;
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_d[c]  = cnt_q[c];
      per_d[c]  = per_q[c];
      mode_d[c] = mode_q[c];

      if (wr_ok && (addr[4:2] == 3'(c))) begin
        hit_cnt[c] = (addr[1:0] == 2'd0);
        hit_per[c] = (addr[1:0] == 2'd1);
        hit_ctl[c] = (addr[1:0] == 2'd2);
        hit_sts[c] = (addr[1:0] == 2'd3);
      end

      // A COUNT write on a tick edge suppresses that tick entirely.
      if (tick && en_q[c] && !hit_cnt[c]) begin
        if (mode_q[c] == MODE_PERIODIC || mode_q[c] == MODE_ONESHOT) begin
          if (cnt_q[c] == per_q[c]) begin
            cnt_d[c]   = '0;
            set_exp[c] = 1'b1;
            if (mode_q[c] == MODE_ONESHOT) en_d[c] = 1'b0;
          end else begin
            // Past the period the counter simply wraps, silently.
            cnt_d[c] = cnt_q[c] + 1'b1;
          end
        end else begin
          cnt_d[c]   = cnt_q[c] + 1'b1;
          set_exp[c] = &cnt_q[c];
        end
      end

      if (hit_cnt[c]) cnt_d[c] = wr_data[CNT_WIDTH-1:0];
      if (hit_per[c]) per_d[c] = wr_data[CNT_WIDTH-1:0];
      if (hit_ctl[c]) begin
        en_d[c]   = wr_data[0];
        mode_d[c] = wr_data[2:1];
        ien_d[c]  = wr_data[3];
      end
      // A new expiry beats a simultaneous clear.
      exp_d[c] = (exp_q[c] & ~(hit_sts[c] & wr_data[0])) | set_exp[c];
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      en_q    <= '0;
      ien_q   <= '0;
      exp_q   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c]  <= '0;
        per_q[c]  <= '0;
        mode_q[c] <= '0;
      end
    end else begin
      presc_q <= presc_d;
      en_q    <= en_d;
      ien_q   <= ien_d;
      exp_q   <= exp_d;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c]  <= cnt_d[c];
        per_q[c]  <= per_d[c];
        mode_q[c] <= mode_d[c];
      end
    end
  end

  // Zero-latency read mux over registered state; unmapped addresses read 0.
  always_comb begin
    rd_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (in_range && (addr[4:2] == 3'(c))) begin
        case (addr[1:0])
          2'd0:    rd_data[CNT_WIDTH-1:0] = cnt_q[c];
          2'd1:    rd_data[CNT_WIDTH-1:0] = per_q[c];
          2'd2:    rd_data[3:0] = {ien_q[c], mode_q[c], en_q[c]};
          default: rd_data[0] = exp_q[c];
        endcase
      end
    end
  end

  assign irq = |(exp_q & ien_q);

endmodule

// File: tb/tb_mmio_multi_timer_core.sv
// Bench for mmio_multi_timer_core: two instances (narrow/fast and wide/
// prescaled) share one slot bus and are compared against a behavioural model.
module tb_mmio_multi_timer_core;

  localparam int NCH_A = 4, CW_A = 8,  DIV_A = 1;
  localparam int NCH_B = 3, CW_B = 32, DIV_B = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        b_cs, b_rd, b_wr;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic [31:0] rd_a, rd_b;
  logic        irq_a, irq_b;

  int checks = 0;
  int fails  = 0;

  logic [31:0] last_a, last_b;
  logic        last_irq_a, last_irq_b;

  // behavioural model state, [instance][channel]
  logic [31:0] m_cnt [2][8];
  logic [31:0] m_per [2][8];
  logic [1:0]  m_mode[2][8];
  bit          m_en  [2][8];
  bit          m_ien [2][8];
  bit          m_exp [2][8];
  int          m_cyc [2];

  always #5 clk = ~clk;

  mmio_multi_timer_core #(.NUM_CH(NCH_A), .CNT_WIDTH(CW_A), .TICK_DIV(DIV_A)) dut_a (
    .clk(clk), .reset_n(reset_n), .cs(b_cs), .read(b_rd), .write(b_wr),
    .addr(b_addr), .wr_data(b_data), .rd_data(rd_a), .irq(irq_a));

  mmio_multi_timer_core #(.NUM_CH(NCH_B), .CNT_WIDTH(CW_B), .TICK_DIV(DIV_B)) dut_b (
    .clk(clk), .reset_n(reset_n), .cs(b_cs), .read(b_rd), .write(b_wr),
    .addr(b_addr), .wr_data(b_data), .rd_data(rd_b), .irq(irq_b));

  function automatic int pnch(int m);  return (m == 0) ? NCH_A : NCH_B; endfunction
  function automatic int pdiv(int m);  return (m == 0) ? DIV_A : DIV_B; endfunction
  function automatic logic [31:0] pmask(int m);
    longint unsigned one = 1;
    int cw = (m == 0) ? CW_A : CW_B;
    return 32'((one << cw) - 1);
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_cyc[m] = 0;
      for (int c = 0; c < 8; c++) begin
        m_cnt[m][c] = 0; m_per[m][c] = 0; m_mode[m][c] = 0;
        m_en[m][c] = 0;  m_ien[m][c] = 0; m_exp[m][c] = 0;
      end
    end
  endtask

  // One clock edge of the model, using the bus values present at that edge.
  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      bit tick = ((m_cyc[m] % pdiv(m)) == pdiv(m) - 1);
      int a    = int'(b_addr);
      bit wr   = b_cs && b_wr && (a < pnch(m) * 4);
      m_cyc[m]++;
      for (int c = 0; c < pnch(m); c++) begin
        bit mine = wr && (a / 4 == c);
        int k = a % 4;
        bit fired = 0;
        if (tick && m_en[m][c] && !(mine && k == 0)) begin
          bit matched = (m_mode[m][c] == 1 || m_mode[m][c] == 2) && (m_cnt[m][c] == m_per[m][c]);
          if (matched) begin
            m_cnt[m][c] = 0;
            fired = 1;
            if (m_mode[m][c] == 2) m_en[m][c] = 0;
          end else begin
            if (m_mode[m][c] != 1 && m_mode[m][c] != 2 && m_cnt[m][c] == pmask(m)) fired = 1;
            m_cnt[m][c] = (m_cnt[m][c] + 1) & pmask(m);
          end
        end
        if (mine && k == 0) m_cnt[m][c] = b_data & pmask(m);
        if (mine && k == 1) m_per[m][c] = b_data & pmask(m);
        if (mine && k == 2) begin
          m_en[m][c] = b_data[0]; m_mode[m][c] = b_data[2:1]; m_ien[m][c] = b_data[3];
        end
        if (mine && k == 3 && b_data[0]) m_exp[m][c] = 0;
        if (fired) m_exp[m][c] = 1;
      end
    end
  endtask

  function automatic logic [31:0] model_rd(int m, int a);
    int c = a / 4;
    if (a >= pnch(m) * 4) return 32'd0;
    case (a % 4)
      0: return m_cnt[m][c];
      1: return m_per[m][c];
      2: return {28'd0, m_ien[m][c], m_mode[m][c], m_en[m][c]};
      default: return {31'd0, m_exp[m][c]};
    endcase
  endfunction

  function automatic logic model_irq(int m);
    logic r = 0;
    for (int c = 0; c < pnch(m); c++) r |= (m_exp[m][c] && m_ien[m][c]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s addr=%0d observed=%h expected=%h", tag, b_addr, obs, expv);
    end
  endtask

  // One bus cycle: drive at the falling edge, check, let the rising edge happen.
  task automatic step(input logic cs_v, input logic wr_v, input logic [4:0] a, input logic [31:0] d);
    b_cs = cs_v; b_wr = wr_v; b_rd = cs_v & ~wr_v; b_addr = a; b_data = d;
    #1;
    last_a = rd_a; last_b = rd_b; last_irq_a = irq_a; last_irq_b = irq_b;
    chk("rd_a", rd_a, model_rd(0, int'(a)));
    chk("rd_b", rd_b, model_rd(1, int'(a)));
    chk("irq_a", {31'd0, irq_a}, {31'd0, model_irq(0)});
    chk("irq_b", {31'd0, irq_b}, {31'd0, model_irq(1)});
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d); step(1'b1, 1'b1, a, d); endtask
  task automatic rd(input logic [4:0] a); step(1'b1, 1'b0, a, 32'd0); endtask

  initial begin
    logic [31:0] seq [6];
    seq = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd0};
    reset_n = 1'b0; b_cs = 0; b_rd = 0; b_wr = 0; b_addr = 0; b_data = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    // ch0 running, then asynchronous reset mid-count
    wr(5'd2, 32'h1);
    for (int i = 0; i < 5; i++) rd(5'd0);
    #2 reset_n = 1'b0;
    model_reset();
    for (int a = 0; a < 16; a++) begin
      b_addr = 5'(a);
      #1;
      chk("rst_rd_a", rd_a, 32'd0);
      chk("rst_rd_b", rd_b, 32'd0);
      chk("rst_irq", {30'd0, irq_a, irq_b}, 32'd0);
      @(negedge clk);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd(5'd0);
      chk("post_rst_cnt", last_a | last_b, 32'd0);
    end

    // periodic ch1, period 4, irq enabled
    wr(5'd5, 32'd4);
    wr(5'd6, 32'hB);
    for (int i = 0; i < 6; i++) begin
      rd(5'd4);
      chk("periodic_seq", last_a, seq[i]);
    end
    rd(5'd7);
    chk("periodic_exp", last_a, 32'd1);
    chk("periodic_irq", {31'd0, last_irq_a}, 32'd1);
    for (int i = 0; i < 5; i++) wr(5'd7, 32'd1);
    wr(5'd6, 32'd0);
    wr(5'd7, 32'd1);
    rd(5'd7);
    chk("periodic_clr", last_a | last_b, 32'd0);

    // one-shot ch2, period 3, no irq
    wr(5'd9, 32'd3);
    wr(5'd10, 32'h5);
    for (int i = 0; i < 50; i++) rd(5'd11);
    chk("oneshot_exp", last_b, 32'd1);
    rd(5'd10);
    chk("oneshot_ctrl", last_b, 32'd4);
    rd(5'd8);
    chk("oneshot_cnt", last_b, 32'd0);
    chk("oneshot_irq", {31'd0, last_irq_b}, 32'd0);

    // free-run wrap on the 8-bit instance
    wr(5'd0, 32'hFE);
    wr(5'd2, 32'h1);
    rd(5'd0); chk("wrap_fe", last_a, 32'hFE);
    rd(5'd0); chk("wrap_ff", last_a, 32'hFF);
    rd(5'd0); chk("wrap_00", last_a, 32'h00);
    rd(5'd3); chk("wrap_exp", last_a, 32'd1);

    // COUNT write on a tick edge, unmapped read and write
    wr(5'd0, 32'h10);
    rd(5'd0); chk("collide_cnt", last_a, 32'h10);
    rd(5'd31); chk("unmapped_rd", last_a | last_b, 32'd0);
    wr(5'd20, 32'hFFFF_FFFF);
    for (int a = 0; a < 16; a++) rd(5'(a));

    // ch0 period 2 and ch3 period 6 together
    wr(5'd2, 32'd0);
    wr(5'd3, 32'd1);
    wr(5'd1, 32'd2);
    wr(5'd13, 32'd6);
    wr(5'd2, 32'hB);
    wr(5'd14, 32'hB);
    for (int i = 0; i < 20; i++) rd(5'd15);
    chk("multi_ch3_exp", last_a, 32'd1);
    wr(5'd3, 32'd1);
    rd(5'd15);
    chk("multi_irq_hold", {31'd0, last_irq_a}, 32'd1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [4:0]  a;
      logic [31:0] d;
      logic        c, w;
      a = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
      c = ($urandom_range(0, 7) != 0);
      w = ($urandom_range(0, 3) == 0);
      case (a[1:0])
        2'd0:    d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 20));
        2'd1:    d = 32'($urandom_range(0, 12));
        default: d = $urandom;
      endcase
      step(c, w, a, d);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
